tx_rr: RTL and testbench

TX_RR -- requirements
Module: tx_rr

---
 rtl/tx_rr.sv | 210 +++++++++++++++++++++
 tb/tb_tx_rr.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_rr.sv
// ---------------------------------------------------------------------------
// tx_rr -- round-robin packet transmitter for one router output channel.
//
// Several switch requesters compete for a single two-phase (toggle) output
// channel.  A round-robin arbiter picks one requester, the module reads that
// requester's packet buffer flit by flit and presents each flit on the
// channel with a ch_req toggle.  The next flit goes out only after the
// receiver answers with a ch_ack toggle.  That acknowledge is asynchronous to
// clk, so it is synchronised before use.
//
// Ports
//   clk        sole clock, all state changes on its rising edge
//   reset      asynchronous, active-low reset
//   ch_req     two-phase request, each toggle presents one flit
//   ch_flit    flit data, stable from one ch_req toggle to the next
//   ch_ack     two-phase acknowledge from the receiver (asynchronous)
//   sw_req     per-port request to send one packet
//   sw_gnt     one-hot grant, all zero when no packet is owned
//   buf_sel    index of the buffer being read
//   buf_addr   flit address within the selected buffer
//   buf_data   combinational read data for buf_sel/buf_addr
//   pkt_count  number of completed packets, wraps modulo 2^16
//
// Parameters
//   ID, SUBID      router / port identifiers
//   SIZE           flit width in bits
//   BUFF_BITS      buffer address width
//   NPORTS         number of switch requesters
//   SEL_BITS       width of buf_sel, 2^SEL_BITS >= NPORTS
//   PKT_LEN        flits per packet, 1 .. 2^BUFF_BITS
//   SYNC_STAGES    depth of the ch_ack synchroniser
//   VERBOSE_DEBUG  0 or 1, debug tracing enable
// ---------------------------------------------------------------------------
module tx_rr #(
   parameter int ID            = 0,
   parameter int SUBID         = 0,
   parameter int SIZE          = 8,
   parameter int BUFF_BITS     = 3,
   parameter int NPORTS        = 4,
   parameter int SEL_BITS      = 2,
   parameter int PKT_LEN       = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int VERBOSE_DEBUG = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 ch_req,
   output logic [SIZE-1:0]      ch_flit,
   input  logic                 ch_ack,
   input  logic [NPORTS-1:0]    sw_req,
   output logic [NPORTS-1:0]    sw_gnt,
   output logic [SEL_BITS-1:0]  buf_sel,
   output logic [BUFF_BITS-1:0] buf_addr,
   input  logic [SIZE-1:0]      buf_data,
   output logic [15:0]          pkt_count
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      DRAIN
   } state_t;

   // The flit counter is one bit wider than buf_addr so that a full packet
   // of 2^BUFF_BITS flits can be counted while buf_addr wraps back to 0.
   localparam logic [BUFF_BITS:0]  LAST_CNT  = (BUFF_BITS+1)'(PKT_LEN);
   localparam logic [BUFF_BITS:0]  CNT_ONE   = (BUFF_BITS+1)'(1);
   localparam logic [SEL_BITS-1:0] LAST_PORT = SEL_BITS'(NPORTS-1);
   localparam logic [SEL_BITS-1:0] SEL_ONE   = SEL_BITS'(1);

   // Parameter sanity checks, evaluated once at elaboration.
   if (NPORTS < 1 || (2 ** SEL_BITS) < NPORTS) begin : g_bad_nports
      $error("tx_rr: NPORTS must be >= 1 and fit in SEL_BITS");
   end
   if (PKT_LEN < 1 || PKT_LEN > (2 ** BUFF_BITS)) begin : g_bad_pkt_len
      $error("tx_rr: PKT_LEN must be in 1 .. 2^BUFF_BITS");
   end
   if (SYNC_STAGES < 1) begin : g_bad_sync
      $error("tx_rr: SYNC_STAGES must be >= 1");
   end
   if (ID < 0 || SUBID < 0) begin : g_bad_ids
      $error("tx_rr: ID and SUBID must be non-negative");
   end
   if (VERBOSE_DEBUG != 0 && VERBOSE_DEBUG != 1) begin : g_bad_verbose
      $error("tx_rr: VERBOSE_DEBUG must be 0 or 1");
   end

   state_t                state;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                  ack_synced;
   logic                  ack_seen;
   logic                  ack_event;
   logic [SEL_BITS-1:0]   rr_ptr;
   logic [SEL_BITS-1:0]   rr_pick;
   logic [NPORTS-1:0]     rr_mask;
   logic [NPORTS-1:0]     owner_mask;
   logic [BUFF_BITS:0]    flit_cnt;
   logic [BUFF_BITS:0]    cnt_inc;

   // Port index reached by stepping 'offset' places past 'base', modulo
   // NPORTS.  base is always below NPORTS, so one subtraction suffices.
   function automatic int rr_index(input logic [SEL_BITS-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NPORTS) begin
         sum = sum - NPORTS;
      end
      return sum;
   endfunction

   // ch_ack crosses into the clk domain through a plain flop chain.  The
   // copy of the synchronised value is refreshed every cycle, so an ack
   // event is a one-cycle pulse on each acknowledge toggle whatever the
   // state; states that do not expect an ack simply ignore the pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_sync <= '0;
         ack_seen <= 1'b0;
      end else begin
         ack_sync[0] <= ch_ack;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            ack_sync[i] <= ack_sync[i-1];
         end
         ack_seen <= ack_synced;
      end
   end

   assign ack_synced = ack_sync[SYNC_STAGES-1];
   assign ack_event  = ack_synced ^ ack_seen;
   assign cnt_inc    = flit_cnt + CNT_ONE;

   // Round-robin choice.  Offsets are walked from the far end down to 0 so
   // the requester closest after the pointer is the last one written and
   // therefore wins.
   always_comb begin
      rr_pick = '0;
      rr_mask = '0;
      for (int i = NPORTS - 1; i >= 0; i--) begin
         if (|(sw_req & (NPORTS'(1) << rr_index(rr_ptr, i)))) begin
            rr_pick = SEL_BITS'(rr_index(rr_ptr, i));
            rr_mask = NPORTS'(1) << rr_index(rr_ptr, i);
         end
      end
   end

   // Packet sequencer.  owner_mask remembers the granted port after sw_gnt
   // has dropped, so DRAIN can wait for that particular requester to let go
   // before a new arbitration round begins.  The round-robin pointer is
   // moved only when a packet completes, so an abandoned packet (reset)
   // does not count as a win.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ch_req     <= 1'b0;
         ch_flit    <= '0;
         sw_gnt     <= '0;
         buf_sel    <= '0;
         buf_addr   <= '0;
         pkt_count  <= '0;
         rr_ptr     <= '0;
         owner_mask <= '0;
         flit_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|sw_req) begin
                  buf_sel    <= rr_pick;
                  buf_addr   <= '0;
                  flit_cnt   <= '0;
                  sw_gnt     <= rr_mask;
                  owner_mask <= rr_mask;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               ch_flit  <= buf_data;
               ch_req   <= ~ch_req;
               flit_cnt <= CNT_ONE;
               buf_addr <= CNT_ONE[BUFF_BITS-1:0];
               state    <= SEND;
            end
            SEND: begin
               if (ack_event) begin
                  if (flit_cnt < LAST_CNT) begin
                     ch_flit  <= buf_data;
                     ch_req   <= ~ch_req;
                     flit_cnt <= cnt_inc;
                     buf_addr <= cnt_inc[BUFF_BITS-1:0];
                  end else begin
                     sw_gnt    <= '0;
                     pkt_count <= pkt_count + 16'd1;
                     rr_ptr    <= (buf_sel == LAST_PORT) ? '0 : buf_sel + SEL_ONE;
                     state     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if ((sw_req & owner_mask) == '0) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_rr.sv
// ---------------------------------------------------------------------------
// tb_tx_rr -- directed self-checking bench for tx_rr.
//
// Two instances share clock and reset:
//   dut_a  NPORTS=4, PKT_LEN=4, SIZE=8, SYNC_STAGES=2
//   dut_b  same but PKT_LEN=1
// Buffer n holds flits {0xA+n, addr}, so buffer 0 is A0..A7, buffer 1 is
// B0..B7 and so on.  The receiver echoes ch_req back on ch_ack after three
// cycles; the echo can be frozen (dut_a) or inverted by hand (dut_b).
// ---------------------------------------------------------------------------
module tb_tx_rr;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   logic        ch_req_a, ch_ack_a;
   logic [7:0]  ch_flit_a, buf_data_a;
   logic [3:0]  sw_req_a, sw_gnt_a;
   logic [1:0]  buf_sel_a;
   logic [2:0]  buf_addr_a;
   logic [15:0] pkt_count_a;

   logic        ch_req_b, ch_ack_b;
   logic [7:0]  ch_flit_b, buf_data_b;
   logic [3:0]  sw_req_b, sw_gnt_b;
   logic [1:0]  buf_sel_b;
   logic [2:0]  buf_addr_b;
   logic [15:0] pkt_count_b;

   logic        echo_en = 1'b1;
   logic        flip_b  = 1'b0;
   logic [2:0]  echo_a, echo_b;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [7:0] flits_a[$];
   logic [3:0] grants_a[$];
   logic [7:0] flits_b[$];
   logic       prev_req_a = 1'b0;
   logic       prev_req_b = 1'b0;
   logic [3:0] prev_gnt_a = 4'b0000;

   tx_rr #(
      .ID(0), .SUBID(0), .SIZE(8), .BUFF_BITS(3), .NPORTS(4), .SEL_BITS(2),
      .PKT_LEN(4), .SYNC_STAGES(2), .VERBOSE_DEBUG(0)
   ) dut_a (
      .clk(clk), .reset(reset),
      .ch_req(ch_req_a), .ch_flit(ch_flit_a), .ch_ack(ch_ack_a),
      .sw_req(sw_req_a), .sw_gnt(sw_gnt_a),
      .buf_sel(buf_sel_a), .buf_addr(buf_addr_a), .buf_data(buf_data_a),
      .pkt_count(pkt_count_a)
   );

   tx_rr #(
      .ID(0), .SUBID(1), .SIZE(8), .BUFF_BITS(3), .NPORTS(4), .SEL_BITS(2),
      .PKT_LEN(1), .SYNC_STAGES(2), .VERBOSE_DEBUG(0)
   ) dut_b (
      .clk(clk), .reset(reset),
      .ch_req(ch_req_b), .ch_flit(ch_flit_b), .ch_ack(ch_ack_b),
      .sw_req(sw_req_b), .sw_gnt(sw_gnt_b),
      .buf_sel(buf_sel_b), .buf_addr(buf_addr_b), .buf_data(buf_data_b),
      .pkt_count(pkt_count_b)
   );

   // Buffer contents: high nibble names the buffer, low bits the address.
   assign buf_data_a = {4'hA + {2'b00, buf_sel_a}, 1'b0, buf_addr_a};
   assign buf_data_b = {4'hA + {2'b00, buf_sel_b}, 1'b0, buf_addr_b};

   // Receiver model: ch_req comes back on ch_ack three cycles later.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         echo_a <= 3'b000;
         echo_b <= 3'b000;
      end else begin
         if (echo_en) begin
            echo_a <= {echo_a[1:0], ch_req_a};
         end
         echo_b <= {echo_b[1:0], ch_req_b};
      end
   end

   assign ch_ack_a = echo_a[2];
   assign ch_ack_b = echo_b[2] ^ flip_b;

   // Channel monitor: logs each flit carried by a ch_req toggle and each new
   // non-zero grant, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         prev_req_a = ch_req_a;
         prev_req_b = ch_req_b;
         prev_gnt_a = sw_gnt_a;
      end else begin
         if (ch_req_a !== prev_req_a) begin
            flits_a.push_back(ch_flit_a);
            prev_req_a = ch_req_a;
         end
         if (ch_req_b !== prev_req_b) begin
            flits_b.push_back(ch_flit_b);
            prev_req_b = ch_req_b;
         end
         if (sw_gnt_a !== prev_gnt_a) begin
            if (sw_gnt_a != 4'b0000) begin
               grants_a.push_back(sw_gnt_a);
            end
            prev_gnt_a = sw_gnt_a;
         end
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance n cycles, ending 1 time unit after a falling edge.
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_pkts(input bit use_b, input logic [15:0] target, input int budget,
                            input string tag);
      for (int i = 0; i < budget && (use_b ? pkt_count_b : pkt_count_a) !== target; i++) begin
         step(1);
      end
      check_output(tag, use_b ? pkt_count_b : pkt_count_a, target);
   endtask

   task automatic wait_flits_a(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && flits_a.size() < n; i++) begin
         step(1);
      end
      check_output(tag, flits_a.size(), n);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      step(2);
      reset = 1'b1;
   endtask

   initial begin
      sw_req_a = 4'b0000;
      sw_req_b = 4'b0000;

      // Asynchronous reset with no clock edge yet.
      #1 reset = 1'b0;
      #2;
      check_output("rst ch_req",    ch_req_a,    1'b0);
      check_output("rst ch_flit",   ch_flit_a,   8'h00);
      check_output("rst sw_gnt",    sw_gnt_a,    4'b0000);
      check_output("rst buf_sel",   buf_sel_a,   2'd0);
      check_output("rst buf_addr",  buf_addr_a,  3'd0);
      check_output("rst pkt_count", pkt_count_a, 16'd0);
      check_output("rst b ch_req",  ch_req_b,    1'b0);
      step(2);
      reset = 1'b1;

      // Single requester on port 0: grant, then first toggle one edge later.
      $display("[TB] single packet from port 0");
      sw_req_a = 4'b0001;
      step(1);
      check_output("grant sw_gnt",   sw_gnt_a,   4'b0001);
      check_output("grant buf_sel",  buf_sel_a,  2'd0);
      check_output("grant buf_addr", buf_addr_a, 3'd0);
      check_output("grant ch_req",   ch_req_a,   1'b0);
      step(1);
      check_output("load ch_req",   ch_req_a,   1'b1);
      check_output("load ch_flit",  ch_flit_a,  8'hA0);
      check_output("load buf_addr", buf_addr_a, 3'd1);
      wait_flits_a(4, 60, "p0 four flits");
      check_output("gnt before last ack", sw_gnt_a, 4'b0001);
      wait_pkts(1'b0, 16'd1, 40, "p0 pkt_count");
      check_output("gnt after last ack", sw_gnt_a, 4'b0000);
      check_output("p0 toggles", flits_a.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check_output($sformatf("p0 flit%0d", i), flits_a[i], 8'hA0 + i[7:0]);
      end
      sw_req_a = 4'b0000;
      step(3);

      // All ports requesting from a fresh reset: strict rotation.
      $display("[TB] round-robin over four ports");
      pulse_reset();
      flits_a.delete();
      grants_a.delete();
      sw_req_a = 4'b1111;
      for (int p = 1; p <= 5; p++) begin
         wait_pkts(1'b0, 16'(p), 60, $sformatf("rr pkt%0d", p));
         sw_req_a = 4'b0000;
         step(1);
         sw_req_a = 4'b1111;
      end
      sw_req_a = 4'b0000;
      check_output("rr grant count", grants_a.size(), 5);
      check_output("rr grant0", grants_a[0], 4'b0001);
      check_output("rr grant1", grants_a[1], 4'b0010);
      check_output("rr grant2", grants_a[2], 4'b0100);
      check_output("rr grant3", grants_a[3], 4'b1000);
      check_output("rr grant4", grants_a[4], 4'b0001);
      check_output("rr flit count", flits_a.size(), 20);
      check_output("rr flit4",  flits_a[4],  8'hB0);
      check_output("rr flit11", flits_a[11], 8'hC3);
      check_output("rr flit15", flits_a[15], 8'hD3);
      check_output("rr flit19", flits_a[19], 8'hA3);
      step(2);

      // One-cycle request on port 2 still yields a whole packet.
      $display("[TB] one-cycle request on port 2");
      flits_a.delete();
      grants_a.delete();
      sw_req_a = 4'b0100;
      step(1);
      sw_req_a = 4'b0000;
      wait_pkts(1'b0, 16'd6, 60, "pulse pkt_count");
      check_output("pulse grant", grants_a[0], 4'b0100);
      check_output("pulse flit count", flits_a.size(), 4);
      check_output("pulse flit0", flits_a[0], 8'hC0);
      check_output("pulse flit3", flits_a[3], 8'hC3);
      sw_req_a = 4'b0001;
      step(2);
      check_output("drain exit regrant", sw_gnt_a, 4'b0001);
      wait_pkts(1'b0, 16'd7, 60, "after drain pkt_count");
      sw_req_a = 4'b0000;
      step(2);

      // Frozen acknowledge: one flit, then the packet stalls.
      $display("[TB] acknowledge held constant");
      echo_en = 1'b0;
      flits_a.delete();
      sw_req_a = 4'b0001;
      step(42);
      check_output("stall toggles",   flits_a.size(), 1);
      check_output("stall sw_gnt",    sw_gnt_a,    4'b0001);
      check_output("stall ch_req",    ch_req_a,    1'b1);
      check_output("stall pkt_count", pkt_count_a, 16'd7);

      // Reset in the middle of a packet.
      $display("[TB] reset after the second flit");
      sw_req_a = 4'b0000;
      pulse_reset();
      echo_en = 1'b1;
      flits_a.delete();
      sw_req_a = 4'b0001;
      wait_flits_a(2, 40, "mid two flits");
      reset = 1'b0;
      #1;
      check_output("mid rst ch_req",    ch_req_a,    1'b0);
      check_output("mid rst ch_flit",   ch_flit_a,   8'h00);
      check_output("mid rst sw_gnt",    sw_gnt_a,    4'b0000);
      check_output("mid rst buf_addr",  buf_addr_a,  3'd0);
      check_output("mid rst pkt_count", pkt_count_a, 16'd0);
      step(3);
      check_output("mid rst no toggle", flits_a.size(), 2);
      flits_a.delete();
      reset = 1'b1;
      wait_pkts(1'b0, 16'd1, 60, "restart pkt_count");
      check_output("restart flit count", flits_a.size(), 4);
      check_output("restart flit0", flits_a[0], 8'hA0);
      check_output("restart flit3", flits_a[3], 8'hA3);
      sw_req_a = 4'b0000;
      step(2);

      // Single-flit packets; stray acknowledges while idle are ignored.
      $display("[TB] single-flit build with idle acknowledges");
      flits_b.delete();
      flip_b = 1'b1;
      step(10);
      flip_b = 1'b0;
      step(10);
      flip_b = 1'b1;
      step(10);
      check_output("idle ack ch_req",    ch_req_b,       1'b0);
      check_output("idle ack toggles",   flits_b.size(), 0);
      check_output("idle ack pkt_count", pkt_count_b,    16'd0);
      sw_req_b = 4'b0001;
      wait_pkts(1'b1, 16'd1, 40, "len1 pkt_count");
      check_output("len1 sw_gnt", sw_gnt_b, 4'b0000);
      check_output("len1 flit0", flits_b[0], 8'hA0);
      sw_req_b = 4'b0000;
      step(10);
      check_output("len1 toggles", flits_b.size(), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
